// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the 4-way round-robin mux arbiter.
//   arb_state_t : FSM state encoding (IDLE, GRANT)
//   NREQ, IDXW  : requester count and index width
//   idx_t       : requester / mux-select index
//   idx2onehot  : index to one-hot grant vector
package mux_arb_pkg;

  localparam int NREQ = 4;
  localparam int IDXW = 2;

  typedef enum logic {IDLE, GRANT} arb_state_t;

  typedef logic [IDXW-1:0] idx_t;

  function automatic logic [NREQ-1:0] idx2onehot(input idx_t idx);
    logic [NREQ-1:0] oh;
    oh = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/mux_rr_arbiter_rr_pick.sv
// Combinational round-robin pick.
//   req   : request vector, bit i = requester i
//   ptr   : last-granted index; scan starts at ptr+1
//   valid : at least one request present
//   pick  : first requester found scanning ptr+1, ptr+2, ptr+3, ptr (mod 4)
module rr_pick
  import mux_arb_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  idx_t            ptr,
  output logic            valid,
  output idx_t            pick
);

  logic [NREQ-1:0] rot;
  idx_t            off;
  logic            found;

  // Rotate so that rot[0] is the requester right after ptr, take the lowest
  // set bit as a fixed-priority winner, then rotate the offset back.
  always_comb begin
    rot   = '0;
    off   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      rot[i] = req[idx_t'(ptr + idx_t'(1) + idx_t'(i))];
    end
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        off   = idx_t'(i);
      end
    end
    valid = found;
    pick  = idx_t'(ptr + idx_t'(1) + off);
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 select mux between four requesters.
// Requester i maps to mux input i ({s1,s0}: 00=aa, 01=bb, 10=cc, 11=dd).
// Each grant is held for at least HOLD_CYCLES cycles; no preemption.
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   req  : request per requester
//   gnt  : registered one-hot grant, zero when no owner
//   s0   : registered mux select LSB
//   s1   : registered mux select MSB
//   busy : high while a grant is active
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int HOLD_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic            s0,
  output logic            s1,
  output logic            busy
);

  localparam int            CW       = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] HOLD_MAX = CW'(HOLD_CYCLES - 1);

  arb_state_t    state;
  idx_t          ptr;
  logic [CW-1:0] cnt;
  logic          pick_valid;
  idx_t          pick;

  rr_pick u_pick (
    .req   (req),
    .ptr   (ptr),
    .valid (pick_valid),
    .pick  (pick)
  );

  // s0/s1 are deliberately left untouched on release so the mux keeps the
  // last owner's input selected while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gnt   <= '0;
      s0    <= 1'b0;
      s1    <= 1'b0;
      busy  <= 1'b0;
      ptr   <= idx_t'(NREQ - 1);
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            state    <= GRANT;
            gnt      <= idx2onehot(pick);
            {s1, s0} <= pick;
            ptr      <= pick;
            cnt      <= '0;
            busy     <= 1'b1;
          end
        end
        GRANT: begin
          if (cnt == HOLD_MAX && !req[ptr]) begin
            state <= IDLE;
            gnt   <= '0;
            busy  <= 1'b0;
          end else if (cnt != HOLD_MAX) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
module tb_mux_rr_arbiter;

  localparam int H = 2;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] gnt;
  logic       s0;
  logic       s1;
  logic       busy;

  mux_rr_arbiter #(.HOLD_CYCLES(H)) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .gnt  (gnt),
    .s0   (s0),
    .s1   (s1),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
  } exp_t;

  exp_t exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic       m_busy;
  logic [3:0] m_gnt;
  logic [1:0] m_sel;
  int         m_ptr;
  int         m_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic [3:0] rq);
    int pk;
    if (r) begin
      m_busy = 1'b0; m_gnt = 4'b0000; m_sel = 2'b00; m_ptr = 3; m_cnt = 0;
    end else if (!m_busy) begin
      pk = -1;
      for (int k = 1; k <= 4; k++) begin
        if (pk < 0 && rq[(m_ptr + k) % 4]) pk = (m_ptr + k) % 4;
      end
      if (pk >= 0) begin
        m_busy = 1'b1;
        m_gnt  = 4'b0000;
        m_gnt[pk] = 1'b1;
        m_sel  = 2'(pk);
        m_ptr  = pk;
        m_cnt  = 0;
      end
    end else begin
      if (m_cnt == H - 1 && !rq[m_ptr]) begin
        m_busy = 1'b0;
        m_gnt  = 4'b0000;
      end else if (m_cnt < H - 1) begin
        m_cnt++;
      end
    end
  endtask

  // Drive one cycle of stimulus, queue the expected post-edge outputs,
  // then compare against what the DUT shows just after the edge.
  task automatic step(input logic [3:0] rq, input logic r);
    exp_t e;
    exp_t got;
    @(negedge clk);
    req = rq;
    rst = r;
    model_step(r, rq);
    e.gnt = m_gnt; e.sel = m_sel; e.busy = m_busy;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      got = exp_q.pop_front();
      check("sb_gnt",  32'(gnt), 32'(got.gnt));
      check("sb_sel",  32'({s1, s0}), 32'(got.sel));
      check("sb_busy", 32'(busy), 32'(got.busy));
    end
  endtask

  initial begin
    rst = 1'b1;
    req = 4'b0000;

    // Reset with all requesting
    step(4'b1111, 1'b1);
    step(4'b1111, 1'b1);
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_sel", 32'({s1, s0}), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    step(4'b1111, 1'b0);
    check("first_gnt", 32'(gnt), 32'h1);
    check("first_sel", 32'({s1, s0}), 32'h0);
    step(4'b0000, 1'b0);
    step(4'b0000, 1'b0);
    check("first_rel", 32'(gnt), 32'h0);

    // Single requester pulsed for one cycle
    step(4'b0100, 1'b0);
    check("single_g1", 32'(gnt), 32'h4);
    check("single_s1", 32'({s1, s0}), 32'h2);
    step(4'b0000, 1'b0);
    check("single_g2", 32'(gnt), 32'h4);
    step(4'b0000, 1'b0);
    check("single_rel", 32'(gnt), 32'h0);
    step(4'b0000, 1'b0);
    check("single_idle_sel", 32'({s1, s0}), 32'h2);
    check("single_idle_busy", 32'(busy), 32'h0);

    // Round robin with all requesting
    step(4'b0000, 1'b1);
    for (int k = 0; k < 5; k++) begin
      logic [3:0] drop;
      step(4'b1111, 1'b0);
      check("rr_gnt", 32'(gnt), 32'(4'b0001 << (k % 4)));
      check("rr_sel", 32'({s1, s0}), 32'(k % 4));
      step(4'b1111, 1'b0);
      check("rr_hold", 32'(gnt), 32'(4'b0001 << (k % 4)));
      drop = 4'b1111 & ~(4'b0001 << (k % 4));
      step(drop, 1'b0);
      check("rr_gap", 32'(gnt), 32'h0);
    end

    // Pointer skip: after owner 1, scan wraps past 2,3 to 0
    step(4'b0000, 1'b1);
    step(4'b0010, 1'b0);
    check("skip_own1", 32'(gnt), 32'h2);
    step(4'b0000, 1'b0);
    step(4'b0000, 1'b0);
    step(4'b0011, 1'b0);
    check("skip_gnt", 32'(gnt), 32'h1);
    check("skip_sel", 32'({s1, s0}), 32'h0);

    // No preemption
    step(4'b0000, 1'b1);
    step(4'b0100, 1'b0);
    check("np_own2", 32'(gnt), 32'h4);
    for (int k = 0; k < 3; k++) begin
      step(4'b1111, 1'b0);
      check("np_hold", 32'(gnt), 32'h4);
    end
    step(4'b1011, 1'b0);
    check("np_rel", 32'(gnt), 32'h0);
    step(4'b1111, 1'b0);
    check("np_next", 32'(gnt), 32'h8);
    check("np_next_sel", 32'({s1, s0}), 32'h3);

    // Mid-grant reset
    step(4'b1111, 1'b1);
    check("mid_rst_gnt", 32'(gnt), 32'h0);
    check("mid_rst_sel", 32'({s1, s0}), 32'h0);
    check("mid_rst_busy", 32'(busy), 32'h0);
    step(4'b1000, 1'b0);
    check("post_rst_gnt", 32'(gnt), 32'h8);

    // Random traffic against the model, with occasional resets
    for (int k = 0; k < 400; k++) begin
      step(4'($urandom_range(0, 15)), ($urandom_range(0, 39) == 0));
    end

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
